seq_arith_unit: RTL
===================

// Module: seq_arith_unit
// PURPOSE
//   Parametrised, handshaked arithmetic unit for the CPU execute stage. ADD, SUB, INC and DEC
//   complete in one cycle. MUL (shift-add) and DIV (restoring) are iterative and take WIDTH
//   cycles each. The unit returns a full result, a high word or remainder, and status flags.
//   It sits between the decode/issue logic and register writeback, beside the logical unit.
// PARAMETERS
//   WIDTH     19   operand/result width in bits (CPU word size)
//   OP_W      3    width of op_sel
// PORTS
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous, active-high reset
//   in_valid    in   1        request valid
//   in_ready    out  1        unit can accept a request
//   op_sel      in   OP_W     0=ADD 1=SUB 2=MUL 3=DIV 4=INC 5=DEC, 6-7 illegal
//   operand_a   in   WIDTH    first operand (dividend for DIV)
//   operand_b   in   WIDTH    second operand (divisor for DIV); ignored by INC/DEC
//   out_valid   out  1        result valid
//   out_ready   in   1        consumer accepts result
//   result      out  WIDTH    low word / quotient
//   result_hi   out  WIDTH    MUL high word / DIV remainder; 0 for other ops
//   flag_carry  out  1        carry-out (ADD/INC) or borrow (SUB/DEC)
//   flag_ovf    out  1        signed overflow (ADD/SUB/INC/DEC); result_hi!=0 (MUL)
//   flag_zero   out  1        result==0
//   flag_dbz    out  1        DIV with operand_b==0
//   flag_ill    out  1        illegal op_sel
// BEHAVIOUR
//   - Reset: all outputs and registers are 0, and the FSM goes to IDLE. in_ready = (state==IDLE) & ~rst.
//   - The FSM has four states: IDLE, MUL_RUN, DIV_RUN and DONE.
//     IDLE --accept--> DONE for 1-cycle ops, dbz and illegal ops; MUL_RUN for MUL; DIV_RUN for DIV.
//     MUL_RUN/DIV_RUN --iteration counter reaches WIDTH--> DONE.
//     DONE --out_ready--> IDLE.
//   - Accept happens when in_valid & in_ready. Operands and op are registered at the accept edge.
//     Inputs may change afterwards without effect. No request overlaps another; in_ready is 0
//     outside IDLE.
//   - Latency, measured from the accept edge N:
//     1-cycle ops, dbz and illegal: out_valid is 1 after edge N+1.
//     MUL and DIV: out_valid is 1 after edge N+WIDTH+1.
//   - out_valid is 1 only in DONE. Result and flags are held stable until the edge where
//     out_ready=1. out_valid then drops on that edge. out_ready is ignored when out_valid=0.
//   - ADD/SUB/INC/DEC are modulo 2^WIDTH. INC adds 1; DEC subtracts 1.
//     Carry is the bit-WIDTH carry-out. Borrow is 1 when a<b unsigned.
//     ovf follows the two's-complement rule: operands share a sign, result sign differs
//     (for SUB, compare against the negated b).
//   - MUL is unsigned. It produces a 2*WIDTH product: result = low word, result_hi = high word.
//     flag_carry = 0.
//   - DIV is unsigned: result = quotient, result_hi = remainder. flag_carry = 0 and flag_ovf = 0.
//   - DIV by 0 skips iteration, takes 1 cycle and sets flag_dbz. result = all-ones;
//     result_hi = operand_a.
//   - Illegal op takes 1 cycle: result = 0, result_hi = 0, flag_ill = 1, all other flags 0.
//   - rst asserted in any state, including mid-iteration, aborts the operation at that edge.
//     No out_valid pulse is produced for the aborted request.
//   - The iteration counter is $clog2(WIDTH+1) bits wide and clears on every accept.
// TESTING (WIDTH=19)
//   - ADD 0x7FFFF+0x00001 -> result 0x00000, carry=1, zero=1, ovf=0.
//     ADD 0x3FFFF+1 -> 0x40000, ovf=1, carry=0. Both give out_valid one cycle after accept.
//   - SUB 5-7 -> result 0x7FFFE, carry(borrow)=1, ovf=0.
//     DEC 0x40000 -> 0x3FFFF, ovf=1.
//   - MUL 0x00400*0x00400 -> result 0x00000, result_hi 0x00002, ovf=1, zero=1.
//     out_valid rises exactly 20 cycles after accept; in_ready stays 0 throughout.
//   - DIV 100/7 -> result 14, result_hi 2, 20-cycle latency.
//     DIV 0x12345/0 -> result 0x7FFFF, result_hi 0x12345, dbz=1, 1-cycle latency.
//   - Backpressure: complete an ADD with out_ready=0 for 5 cycles -> outputs stable,
//     in_ready=0; out_ready=1 -> out_valid drops next edge, in_ready rises.
//   - Assert rst on iteration 8 of a MUL -> no out_valid; in_ready=1 the cycle after rst falls.
//     A following ADD 2+3 returns 5 correctly. op_sel=7 -> ill=1, result 0.

Source files
------------

// File: rtl/seq_arith_unit.sv
// Execute-stage arithmetic unit: single-cycle ADD/SUB/INC/DEC, iterative shift-add MUL
// and restoring DIV, behind a valid/ready handshake on both sides.
module seq_arith_unit #(
  parameter int WIDTH = 19,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op_sel,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_zero,
  output logic             flag_dbz,
  output logic             flag_ill
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_INC = OP_W'(4);
  localparam logic [OP_W-1:0] OP_DEC = OP_W'(5);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q, quo_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q, result_hi_q;
  logic               carry_q, ovf_q, zero_q, dbz_q, ill_q;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     add_ext, sub_ext, mul_sum, rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   res_d, hi_d;
  logic               carry_d, ovf_d, zero_d, dbz_d, ill_d;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_sel == OP_MUL)                            state_d = MUL_RUN;
          else if (op_sel == OP_DIV && operand_b != '0)    state_d = DIV_RUN;
          else                                             state_d = DONE;
        end
      end
      MUL_RUN, DIV_RUN: if (last_iter) state_d = DONE;
      DONE:             if (out_valid_q && out_ready) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) & ~rst;
    out_valid = out_valid_q;
  end

  // One iteration step of each multi-cycle algorithm
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, b_q};
  end

  // Final result/flags, evaluated on the first DONE cycle from the registered operands
  always_comb begin
    b_eff   = (op_q == OP_INC || op_q == OP_DEC) ? WIDTH'(1) : b_q;
    add_ext = {1'b0, a_q} + {1'b0, b_eff};
    sub_ext = {1'b0, a_q} - {1'b0, b_eff};
    res_d   = '0;
    hi_d    = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dbz_d   = 1'b0;
    ill_d   = 1'b0;
    case (op_q)
      OP_ADD, OP_INC: begin
        res_d   = add_ext[WIDTH-1:0];
        carry_d = add_ext[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        res_d   = sub_ext[WIDTH-1:0];
        carry_d = sub_ext[WIDTH];
        ovf_d   = (a_q[WIDTH-1] != b_eff[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res_d = prod_q[WIDTH-1:0];
        hi_d  = prod_q[2*WIDTH-1:WIDTH];
        ovf_d = |hi_d;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_d = '1;
          hi_d  = a_q;
          dbz_d = 1'b1;
        end else begin
          res_d = quo_q;
          hi_d  = rem_q;
        end
      end
      default: ill_d = 1'b1;
    endcase
    zero_d = ~ill_d & (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= op_sel;
            a_q    <= operand_a;
            b_q    <= operand_b;
            cnt_q  <= '0;
            prod_q <= {{WIDTH{1'b0}}, operand_b};
            rem_q  <= '0;
            quo_q  <= operand_a;
          end
        end
        MUL_RUN: begin
          prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
        end
        DIV_RUN: begin
          if (div_diff[WIDTH+1]) begin
            rem_q <= rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_q <= div_diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end
          cnt_q <= cnt_q + CW'(1);
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            result_hi_q <= hi_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign flag_zero  = zero_q;
  assign flag_dbz   = dbz_q;
  assign flag_ill   = ill_q;

endmodule
